// File: rtl/regs.sv
// Integer register file with per-register pending-write scoreboard.
// Define REGS_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        wb_reg_wen_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic [31:0] wb_rd_data_i,
  input  logic        iss_reg_wen_i,
  input  logic [4:0]  iss_rd_addr_i,
  input  logic        flush_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o
);

  logic [31:0] mem     [32];
  logic [1:0]  cnt     [32];
  logic [1:0]  cnt_nxt [32];
  logic        wb_hit;
  logic        iss_hit;
  logic [31:0] rs1_raw;
  logic [31:0] rs2_raw;
  logic [1:0]  rs1_cnt;
  logic [1:0]  rs2_cnt;
  logic        rs1_byp;
  logic        rs2_byp;

  assign wb_hit  = wb_reg_wen_i && (wb_rd_addr_i != 5'd0);
  assign iss_hit = iss_reg_wen_i && (iss_rd_addr_i != 5'd0);

  // Storage: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wb_hit) begin
      mem[wb_rd_addr_i] <= wb_rd_data_i;
    end
  end

  // Next pending count per register: saturating inc/dec, flush wins.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      logic inc;
      logic dec;
      cnt_nxt[i] = cnt[i];
      inc = iss_hit && (iss_rd_addr_i == 5'(i));
      dec = wb_hit && (wb_rd_addr_i == 5'(i));
      if (flush_i || i == 0) begin
        cnt_nxt[i] = 2'd0;
      end else if (inc && !dec && cnt[i] != 2'd3) begin
        cnt_nxt[i] = cnt[i] + 2'd1;
      end else if (dec && !inc && cnt[i] != 2'd0) begin
        cnt_nxt[i] = cnt[i] - 2'd1;
      end
    end
  end

  // Scoreboard count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 32; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Combinational read, optional forwarding, outputs forced low in reset.
  always_comb begin
    rs1_raw = (rs1_addr_i == 5'd0) ? 32'd0 : mem[rs1_addr_i];
    rs2_raw = (rs2_addr_i == 5'd0) ? 32'd0 : mem[rs2_addr_i];
    rs1_cnt = cnt[rs1_addr_i];
    rs2_cnt = cnt[rs2_addr_i];
`ifdef REGS_BYPASS_EN
    rs1_byp = wb_hit && (wb_rd_addr_i == rs1_addr_i);
    rs2_byp = wb_hit && (wb_rd_addr_i == rs2_addr_i);
`else
    rs1_byp = 1'b0;
    rs2_byp = 1'b0;
`endif
    rs1_data_o = rs1_byp ? wb_rd_data_i : rs1_raw;
    rs2_data_o = rs2_byp ? wb_rd_data_i : rs2_raw;
    rs1_busy_o = (rs1_cnt > 2'd1) || (rs1_cnt == 2'd1 && !rs1_byp);
    rs2_busy_o = (rs2_cnt > 2'd1) || (rs2_cnt == 2'd1 && !rs2_byp);
    if (!rst_n) begin
      rs1_data_o = '0;
      rs2_data_o = '0;
      rs1_busy_o = 1'b0;
      rs2_busy_o = 1'b0;
    end
  end

endmodule

// File: doc/regs.md
REGS -- requirements
Module: regs

Interface
REQ-001 The block SHALL have these ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have these ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have these ports: rs1_addr_i  input  5  read port 1 address, driven by the decode stage.
REQ-004 The block SHALL have these ports: rs2_addr_i  input  5  read port 2 address, driven by the decode stage.
REQ-005 The block SHALL have these ports: rs1_data_o  output  32  read port 1 data, returned to the decode stage.
REQ-006 The block SHALL have these ports: rs2_data_o  output  32  read port 2 data, returned to the decode stage.
REQ-007 The block SHALL have these ports: wb_reg_wen_i  input  1  write-back write enable.
REQ-008 The block SHALL have these ports: wb_rd_addr_i  input  5  write-back destination register.
REQ-009 The block SHALL have these ports: wb_rd_data_i  input  32  write-back data.
REQ-010 The block SHALL have these ports: iss_reg_wen_i  input  1  an instruction with a register write is leaving decode this cycle.
REQ-011 The block SHALL have these ports: iss_rd_addr_i  input  5  destination register of the issuing instruction.
REQ-012 The block SHALL have these ports: flush_i  input  1  pipeline flush; cancels all in-flight writes.
REQ-013 The block SHALL have these ports: rs1_busy_o  output  1  rs1 has an outstanding write that is not yet written back.
REQ-014 The block SHALL have these ports: rs2_busy_o  output  1  rs2 has an outstanding write that is not yet written back.

Function
REQ-015 The storage SHALL be 32 entries of 32 bits; x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-016 A write SHALL occur on the rising clk edge when wb_reg_wen_i=1 and wb_rd_addr_i!=0.
REQ-017 Reads SHALL be combinational (zero latency) from rs*_addr_i to rs*_data_o.
REQ-018 The scoreboard SHALL hold a 2-bit pending count per register (x1..x31), saturating at 3; x0 SHALL never be busy.
REQ-019 On a clock edge with iss_reg_wen_i=1 and iss_rd_addr_i!=0, the count for iss_rd_addr_i SHALL increment (saturating).
REQ-020 On a clock edge with wb_reg_wen_i=1 and wb_rd_addr_i!=0, the count for wb_rd_addr_i SHALL decrement (never below 0).
REQ-021 If issue and write-back target the same register in the same cycle, its count SHALL be unchanged.
REQ-022 rsN_busy_o SHALL be 1 iff the count for rsN_addr_i is nonzero, excluding any write-back that completes this cycle to that same address.
REQ-023 When flush_i=1, all counts SHALL clear to 0 at the next edge, taking priority over issue and write-back on the scoreboard.
REQ-024 A write-back in the same cycle as flush_i SHALL still update storage.

Reset
REQ-025 When rst_n=0, all 31 registers and all scoreboard counts SHALL clear to 0 immediately, independent of clk.
REQ-026 During reset, rs*_data_o SHALL be 0 and rs*_busy_o SHALL be 0.
REQ-027 Reset SHALL release synchronously to the first clk edge after rst_n rises; no write SHALL occur on that edge if rst_n was low at it.

Configuration
REQ-028 With REGS_BYPASS_EN defined: when wb_reg_wen_i=1, wb_rd_addr_i!=0 and wb_rd_addr_i==rsN_addr_i, rsN_data_o SHALL equal wb_rd_data_i in the same cycle.
REQ-029 Without REGS_BYPASS_EN: rsN_data_o SHALL show only stored contents (new data visible the cycle after the write), and busy SHALL be based on the count alone, with no same-cycle write-back exclusion.

Verification
REQ-030 Scenario: after reset, read x1..x31 -> every read returns 0 and both busy outputs are 0.
REQ-031 Scenario: write x5=0xDEADBEEF, then read rs1=x5 next cycle -> 0xDEADBEEF; write x0=0x1234 -> x0 still reads 0.
REQ-032 Scenario (bypass on): write-back x7=0xA5A5A5A5 with rs2_addr_i=7 in the same cycle -> rs2_data_o=0xA5A5A5A5 that cycle; with bypass off -> old value that cycle, new value the next cycle.
REQ-033 Scenario: issue x3 twice on consecutive cycles, write back x3 once -> rs1_busy_o(x3) stays 1; after the second write-back -> 0.
REQ-034 Scenario: issue x9 and write back x9 in the same cycle with count=1 -> count stays 1 and busy stays 1; then flush_i -> busy=0 on the next cycle.
REQ-035 Scenario: assert rst_n=0 mid-cycle with x4=0x55 and x4 busy -> x4 reads 0 and busy=0 immediately, with no clk edge required.
